serial_sub: RTL

- Bit-serial two's-complement subtractor: computes D = A - B one bit per clock, LSB first, using a single full-subtractor cell with a registered borrow.
- Counterpart to the combinational ripple adders in the arithmetic library; trades latency for area.
- Valid/ready handshake on both sides, so it drops into pipelined datapaths that already consume adder results.

---
 rtl/serial_sub.sv | 109 ++++++++++
 1 files changed

// File: rtl/serial_sub.sv
// Bit-serial two's-complement subtractor: one full-subtractor cell and a
// registered borrow produce D = A - B LSB first, with valid/ready on both sides.
module serial_sub #(
  parameter int WIDTH = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] d,
  output logic             borrow_out,
  output logic             overflow
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  function automatic logic fs_diff(input logic ai, input logic bi, input logic bor);
    return ai ^ bi ^ bor;
  endfunction

  function automatic logic fs_borrow(input logic ai, input logic bi, input logic bor);
    return (~ai & bi) | (~(ai ^ bi) & bor);
  endfunction

  state_t           state_q;
  logic [WIDTH-1:0] a_q, b_q, d_q;
  logic [WIDTH-2:0] res_q;
  logic [CW-1:0]    cnt_q;
  logic             bor_q, a_msb_q, b_msb_q;
  logic             in_ready_q, out_valid_q, borrow_q, ovf_q;

  logic             diff_d, bor_d, last_bit;
  logic [WIDTH-1:0] res_d;

  // res_q only needs WIDTH-1 slots: the final diff bit completes the word
  // directly into d_q on the last RUN edge.
  assign diff_d   = fs_diff(a_q[0], b_q[0], bor_q);
  assign bor_d    = fs_borrow(a_q[0], b_q[0], bor_q);
  assign res_d    = {diff_d, res_q};
  assign last_bit = (cnt_q == CW'(WIDTH - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      res_q       <= '0;
      d_q         <= '0;
      cnt_q       <= '0;
      bor_q       <= 1'b0;
      a_msb_q     <= 1'b0;
      b_msb_q     <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      borrow_q    <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_q        <= a;
            b_q        <= b;
            bor_q      <= 1'b0;
            cnt_q      <= '0;
            a_msb_q    <= a[WIDTH-1];
            b_msb_q    <= b[WIDTH-1];
            in_ready_q <= 1'b0;
            state_q    <= RUN;
          end
        end
        RUN: begin
          a_q   <= a_q >> 1;
          b_q   <= b_q >> 1;
          bor_q <= bor_d;
          res_q <= res_d[WIDTH-1:1];
          cnt_q <= cnt_q + CW'(1);
          if (last_bit) begin
            d_q         <= res_d;
            borrow_q    <= bor_d;
            ovf_q       <= (a_msb_q ^ b_msb_q) & (diff_d ^ a_msb_q);
            out_valid_q <= 1'b1;
            state_q     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready   = in_ready_q;
  assign out_valid  = out_valid_q;
  assign d          = d_q;
  assign borrow_out = borrow_q;
  assign overflow   = ovf_q;

endmodule
